reg_file_8x8_wb: RTL and testbench

REG_FILE_8X8_WB -- requirements
Module: reg_file_8x8_wb

---
 rtl/reg_file_8x8_wb.sv | 66 ++++++
 tb/tb_reg_file_8x8_wb.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_8x8_wb.sv
// 8x8 register file with one write-back stage between the ALU mux and the array.
// Define REG_BYPASS_EN to forward the pending write-back value to the read ports.
module reg_file_8x8_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              WB_PENDING
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              commit;

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    commit     = 1'b0;
    if (!BUSYWAIT) begin
      wb_valid_d = WRITE;
      wb_addr_d  = INADDRESS;
      wb_data_d  = IN;
      commit     = wb_valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      if (commit) rf_q[wb_addr_q] <= wb_data_q;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_comb begin
    OUT1 = rf_q[OUT1ADDRESS];
    OUT2 = rf_q[OUT2ADDRESS];
`ifdef REG_BYPASS_EN
    if (wb_valid_q && wb_addr_q == OUT1ADDRESS) OUT1 = wb_data_q;
    if (wb_valid_q && wb_addr_q == OUT2ADDRESS) OUT2 = wb_data_q;
`endif
  end

  assign WB_PENDING = wb_valid_q;

endmodule

// File: tb/tb_reg_file_8x8_wb.sv
// Directed vector bench for reg_file_8x8_wb.
// Expected values follow the REG_BYPASS_EN setting of the build.
module tb_reg_file_8x8_wb;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, WRITE, BUSYWAIT;
  logic [7:0] IN;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
  logic [7:0] OUT1, OUT2;
  logic       WB_PENDING;

  int total = 0;
  int bad   = 0;

  reg_file_8x8_wb #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .IN(IN),
    .INADDRESS(INADDRESS),
    .WRITE(WRITE),
    .BUSYWAIT(BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1),
    .OUT2(OUT2),
    .WB_PENDING(WB_PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, wr, bw;
    logic [2:0] ia, a1, a2;
    logic [7:0] din;
    logic [7:0] e1n, e2n, e1b, e2b;
    logic       ep;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic rst, input logic wr, input logic bw,
    input logic [2:0] ia, input logic [7:0] din,
    input logic [2:0] a1, input logic [2:0] a2,
    input logic [7:0] e1n, input logic [7:0] e2n,
    input logic [7:0] e1b, input logic [7:0] e2b,
    input logic ep);
    vec_t v;
    v.rst = rst; v.wr = wr; v.bw = bw;
    v.ia = ia; v.din = din; v.a1 = a1; v.a2 = a2;
    v.e1n = e1n; v.e2n = e2n; v.e1b = e1b; v.e2b = e2b;
    v.ep = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic bw,
                       input logic [2:0] ia, input logic [7:0] din,
                       input logic [2:0] a1, input logic [2:0] a2);
    RESET = rst; WRITE = wr; BUSYWAIT = bw;
    INADDRESS = ia; IN = din;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v.rst, v.wr, v.bw, v.ia, v.din, v.a1, v.a2);
    tick();
    check({tag, ".out1"}, OUT1, BYP ? v.e1b : v.e1n);
    check({tag, ".out2"}, OUT2, BYP ? v.e2b : v.e2n);
    check({tag, ".pend"}, {7'd0, WB_PENDING}, {7'd0, v.ep});
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    tick();

    // reset while a write is requested
    tv.push_back(mk(1,1,0, 3,8'hAA, 3,3, 8'h00,8'h00, 8'h00,8'h00, 0));
    // write A5 to R3: visible one edge later with bypass, two without
    tv.push_back(mk(0,1,0, 3,8'hA5, 3,0, 8'h00,8'h00, 8'hA5,8'h00, 1));
    tv.push_back(mk(0,0,0, 0,8'h00, 3,3, 8'hA5,8'hA5, 8'hA5,8'hA5, 0));
    // back-to-back writes to R5
    tv.push_back(mk(0,1,0, 5,8'h11, 5,5, 8'h00,8'h00, 8'h11,8'h11, 1));
    tv.push_back(mk(0,1,0, 5,8'h22, 5,5, 8'h11,8'h11, 8'h22,8'h22, 1));
    tv.push_back(mk(0,0,0, 0,8'h00, 5,5, 8'h22,8'h22, 8'h22,8'h22, 0));
    tv.push_back(mk(0,0,0, 0,8'h00, 5,5, 8'h22,8'h22, 8'h22,8'h22, 0));
    // write 77 to R6 then reset before commit
    tv.push_back(mk(0,1,0, 6,8'h77, 6,3, 8'h00,8'hA5, 8'h77,8'hA5, 1));
    tv.push_back(mk(1,0,0, 0,8'h00, 6,3, 8'h00,8'h00, 8'h00,8'h00, 0));
    tv.push_back(mk(0,0,0, 0,8'h00, 6,5, 8'h00,8'h00, 8'h00,8'h00, 0));
    // streaming writes R0..R7 = 10+i
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ai, ap;
      logic [7:0] prev;
      ai   = 3'(i);
      ap   = 3'(i + 7);
      prev = (i == 0) ? 8'h00 : 8'(8'h10 + i - 1);
      tv.push_back(mk(0,1,0, ai,8'(8'h10 + i), ai,ap,
                      8'h00,prev, 8'(8'h10 + i),prev, 1));
    end
    tv.push_back(mk(0,0,0, 0,8'h00, 7,6, 8'h17,8'h16, 8'h17,8'h16, 0));
    for (int j = 0; j < 8; j++) begin
      logic [2:0] aj;
      logic [7:0] ej;
      aj = 3'(j);
      ej = 8'(8'h10 + j);
      tv.push_back(mk(0,0,0, 0,8'h00, aj,aj, ej,ej, ej,ej, 0));
    end

    foreach (tv[k]) apply(tv[k], $sformatf("v%0d", k));

    // stall holds a pending write to R1 and ignores new writes to R2
    drive(1'b0, 1'b1, 1'b0, 3'd1, 8'h3C, 3'd1, 3'd2);
    tick();
    check("bw.arm.pend", {7'd0, WB_PENDING}, 8'd1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd2, 8'hFF, 3'd1, 3'd2);
      tick();
      check($sformatf("bw.s%0d.out1", c), OUT1, BYP ? 8'h3C : 8'h11);
      check($sformatf("bw.s%0d.out2", c), OUT2, 8'h12);
      check($sformatf("bw.s%0d.pend", c), {7'd0, WB_PENDING}, 8'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd2);
    tick();
    check("bw.rel.out1", OUT1, 8'h3C);
    check("bw.rel.out2", OUT2, 8'h12);
    check("bw.rel.pend", {7'd0, WB_PENDING}, 8'd0);
    tick();
    check("bw.idle.out2", OUT2, 8'h12);

    // pending write to R4, then reset during a stall
    drive(1'b0, 1'b1, 1'b0, 3'd4, 8'h5A, 3'd4, 3'd4);
    tick();
    check("rst.arm.pend", {7'd0, WB_PENDING}, 8'd1);
    drive(1'b1, 1'b1, 1'b1, 3'd4, 8'h99, 3'd4, 3'd4);
    tick();
    check("rst.pend", {7'd0, WB_PENDING}, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4);
    tick();
    check("rst.r4", OUT1, 8'h00);
    for (int r = 0; r < 8; r++) begin
      OUT1ADDRESS = 3'(r);
      OUT2ADDRESS = 3'(7 - r);
      #1;
      check($sformatf("rst.r%0d.out1", r), OUT1, 8'h00);
      check($sformatf("rst.r%0d.out2", r), OUT2, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
